// File: rtl/dot_operand_loader.sv
// dot_operand_loader
//
// Upstream feeder for naive_dot. Collects weight/activation element pairs
// arriving LANES at a time on a valid/ready beat stream, assembles them into
// one N-element vector, and issues that vector to the downstream engine with
// a one-cycle start strobe. Issued-but-unfinished vectors are counted against
// returned done pulses, and issue is throttled at MAX_OUT outstanding.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_valid may be dropped at any time (assembly simply pauses); in_ready
// depends only on registered state, never on in_valid or done_in.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        beat valid
//   in_ready        beat accepted when in_valid && in_ready
//   in_weights      LANES weights, lane j at [j*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   in_acts         LANES activations, lane j at [j*ACT_WIDTH +: ACT_WIDTH]
//   in_last         sender's end-of-vector mark, checked only
//   done_in         downstream completion pulse, one per issued vector
//   start           one-cycle issue strobe
//   o_weights_flat  assembled weights, element i at [i*WEIGHT_WIDTH +: ...]
//   o_acts_flat     assembled activations, same indexing
//   outstanding     issued vectors not yet completed
//   vec_cnt         vectors issued, wraps at 2^16
//   err_framing     sticky: in_last disagreed with the beat position
//   err_underflow   sticky: done_in seen with nothing outstanding

module dot_operand_loader #(
   parameter int N            = 128,
   parameter int WEIGHT_WIDTH = 4,
   parameter int ACT_WIDTH    = 4,
   parameter int LANES        = 8,
   parameter int MAX_OUT      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [LANES*WEIGHT_WIDTH-1:0]   in_weights,
   input  logic [LANES*ACT_WIDTH-1:0]      in_acts,
   input  logic                            in_last,
   input  logic                            done_in,
   output logic                            start,
   output logic [N*WEIGHT_WIDTH-1:0]       o_weights_flat,
   output logic [N*ACT_WIDTH-1:0]          o_acts_flat,
   output logic [$clog2(MAX_OUT+1)-1:0]    outstanding,
   output logic [15:0]                     vec_cnt,
   output logic                            err_framing,
   output logic                            err_underflow
);

   localparam int BEATS = N / LANES;
   // Keep the beat counter at least one bit wide so BEATS==1 still elaborates.
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OW    = $clog2(MAX_OUT + 1);

   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [OW-1:0]  MAX_CNT   = OW'(MAX_OUT);

   logic [BCW-1:0]            beat_cnt;
   logic [N*WEIGHT_WIDTH-1:0] w_buf;
   logic [N*ACT_WIDTH-1:0]    a_buf;
   logic [N*WEIGHT_WIDTH-1:0] w_buf_next;
   logic [N*ACT_WIDTH-1:0]    a_buf_next;

   logic final_beat;
   logic accept;
   logic final_accept;

   assign final_beat   = (beat_cnt == LAST_BEAT);
   // Only the final beat of a vector can stall: earlier beats just fill the
   // buffer, and the final one needs a credit because it triggers an issue.
   assign in_ready     = !(final_beat && (outstanding == MAX_CNT));
   assign accept       = in_valid && in_ready;
   assign final_accept = accept && final_beat;

   // Fill buffer with the current beat's lanes merged in. The output
   // registers load from this merged view so the final beat's own lanes are
   // included in the issued vector without an extra cycle.
   always_comb begin
      w_buf_next = w_buf;
      a_buf_next = a_buf;
      for (int j = 0; j < LANES; j++) begin
         w_buf_next[(int'(beat_cnt) * LANES + j) * WEIGHT_WIDTH +: WEIGHT_WIDTH]
            = in_weights[j * WEIGHT_WIDTH +: WEIGHT_WIDTH];
         a_buf_next[(int'(beat_cnt) * LANES + j) * ACT_WIDTH +: ACT_WIDTH]
            = in_acts[j * ACT_WIDTH +: ACT_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt       <= '0;
         w_buf          <= '0;
         a_buf          <= '0;
         o_weights_flat <= '0;
         o_acts_flat    <= '0;
         start          <= 1'b0;
         outstanding    <= '0;
         vec_cnt        <= '0;
         err_framing    <= 1'b0;
         err_underflow  <= 1'b0;
      end else begin
         start <= final_accept;

         if (accept) begin
            w_buf    <= w_buf_next;
            a_buf    <= a_buf_next;
            beat_cnt <= final_beat ? '0 : beat_cnt + BCW'(1);
            // in_last is advisory: a mismatch is flagged but never changes
            // how the beat is placed or counted.
            if (in_last != final_beat) begin
               err_framing <= 1'b1;
            end
         end

         // Output registers are separate from the fill buffer, so the next
         // vector can start filling immediately after this one issues.
         if (final_accept) begin
            o_weights_flat <= w_buf_next;
            o_acts_flat    <= a_buf_next;
         end

         if (start) begin
            vec_cnt <= vec_cnt + 16'd1;
         end

         // An issue and a completion in the same cycle cancel out.
         if (final_accept && !done_in) begin
            outstanding <= outstanding + OW'(1);
         end else if (!final_accept && done_in && (outstanding != '0)) begin
            outstanding <= outstanding - OW'(1);
         end

         if (done_in && (outstanding == '0)) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dot_operand_loader.sv
// Directed bench for dot_operand_loader, built with MAX_OUT=2 so the credit
// stall is reachable with a handful of vectors. Element i of a vector built
// with seed s carries weight (i+s)%16 and activation (15-i+s)%16.

module tb_dot_operand_loader;

   localparam int N     = 128;
   localparam int WW    = 4;
   localparam int AW    = 4;
   localparam int LANES = 8;
   localparam int MAXO  = 2;
   localparam int BEATS = N / LANES;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*WW-1:0]   in_weights;
   logic [LANES*AW-1:0]   in_acts;
   logic                  in_last;
   logic                  done_in;
   logic                  start;
   logic [N*WW-1:0]       o_weights_flat;
   logic [N*AW-1:0]       o_acts_flat;
   logic [1:0]            outstanding;
   logic [15:0]           vec_cnt;
   logic                  err_framing;
   logic                  err_underflow;

   int tests = 0;
   int fails = 0;

   dot_operand_loader #(
      .N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .LANES(LANES), .MAX_OUT(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_weights(in_weights), .in_acts(in_acts), .in_last(in_last),
      .done_in(done_in), .start(start),
      .o_weights_flat(o_weights_flat), .o_acts_flat(o_acts_flat),
      .outstanding(outstanding), .vec_cnt(vec_cnt),
      .err_framing(err_framing), .err_underflow(err_underflow)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expected-value model ----------------
   function automatic logic [N*WW-1:0] exp_w(input int seed);
      logic [N*WW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*WW +: WW] = 4'((i + seed) & 15);
      return r;
   endfunction

   function automatic logic [N*AW-1:0] exp_a(input int seed);
      logic [N*AW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*AW +: AW] = 4'((15 - i + seed) & 15);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns 1 time unit after the edge
   // that accepted the beat. in_valid is left high for the caller.
   task automatic send_beat(input int seed, input int k, input logic last);
      logic [N*WW-1:0] w;
      logic [N*AW-1:0] a;
      int waited;
      w = exp_w(seed);
      a = exp_a(seed);
      in_weights = w[k*LANES*WW +: LANES*WW];
      in_acts    = a[k*LANES*AW +: LANES*AW];
      in_last    = last;
      in_valid   = 1'b1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      tests++;
      assert (in_ready === 1'b1) else begin
         fails++;
         $error("FAIL ready_timeout beat=%0d observed=%b expected=1", k, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_vec(input int seed);
      for (int k = 0; k < BEATS; k++) send_beat(seed, k, k == BEATS - 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_done();
      done_in = 1'b1;
      @(posedge clk); #1;
      done_in = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
      chk({tag, "_start"}, 512'(start), 512'(0));
      chk({tag, "_w_flat"}, o_weights_flat, 512'(0));
      chk({tag, "_a_flat"}, o_acts_flat, 512'(0));
      chk({tag, "_outstanding"}, 512'(outstanding), 512'(0));
      chk({tag, "_vec_cnt"}, 512'(vec_cnt), 512'(0));
      chk({tag, "_err_framing"}, 512'(err_framing), 512'(0));
      chk({tag, "_err_underflow"}, 512'(err_underflow), 512'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_weights = '0;
      in_acts    = '0;
      in_last    = 1'b0;
      done_in    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single vector: start one cycle after the final beat.
      send_vec(0);
      chk("single_start", 512'(start), 512'(1));
      chk("single_w_flat", o_weights_flat, exp_w(0));
      chk("single_a_flat", o_acts_flat, exp_a(0));
      chk("single_outstanding", 512'(outstanding), 512'(1));
      chk("single_err_framing", 512'(err_framing), 512'(0));
      @(posedge clk); #1;
      chk("single_start_drop", 512'(start), 512'(0));
      chk("single_vec_cnt", 512'(vec_cnt), 512'(1));
      chk("single_w_hold", o_weights_flat, exp_w(0));

      // done_in coincident with final-beat acceptance at outstanding=1.
      for (int k = 0; k < BEATS - 1; k++) send_beat(3, k, 1'b0);
      done_in = 1'b1;
      send_beat(3, BEATS - 1, 1'b1);
      done_in  = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("simul_start", 512'(start), 512'(1));
      chk("simul_outstanding", 512'(outstanding), 512'(1));
      chk("simul_w_flat", o_weights_flat, exp_w(3));
      chk("simul_a_flat", o_acts_flat, exp_a(3));
      @(posedge clk); #1;
      chk("simul_vec_cnt", 512'(vec_cnt), 512'(2));

      // Credit stall: fill up to MAX_OUT, then the next final beat waits.
      send_vec(5);
      chk("credit_fill_outstanding", 512'(outstanding), 512'(2));
      for (int k = 0; k < BEATS - 1; k++) send_beat(7, k, 1'b0);
      in_weights = exp_w(7) >> ((BEATS - 1) * LANES * WW);
      in_acts    = exp_a(7) >> ((BEATS - 1) * LANES * AW);
      in_last    = 1'b1;
      in_valid   = 1'b1;
      chk("stall_ready_low", 512'(in_ready), 512'(0));
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("stall_ready_held", 512'(in_ready), 512'(0));
      chk("stall_no_start", 512'(start), 512'(0));
      chk("stall_outstanding", 512'(outstanding), 512'(2));
      done_in = 1'b1;
      #1;
      chk("stall_ready_same_cycle", 512'(in_ready), 512'(0));
      @(posedge clk); #1;
      done_in = 1'b0;
      chk("stall_release_outstanding", 512'(outstanding), 512'(1));
      chk("stall_release_ready", 512'(in_ready), 512'(1));
      chk("stall_release_no_start", 512'(start), 512'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("stall_third_start", 512'(start), 512'(1));
      chk("stall_third_outstanding", 512'(outstanding), 512'(2));
      chk("stall_third_w_flat", o_weights_flat, exp_w(7));
      chk("stall_third_a_flat", o_acts_flat, exp_a(7));
      @(posedge clk); #1;
      chk("stall_vec_cnt", 512'(vec_cnt), 512'(4));
      pulse_done();
      pulse_done();
      chk("drain_outstanding", 512'(outstanding), 512'(0));
      chk("drain_no_underflow", 512'(err_underflow), 512'(0));

      // Framing: in_last on beat 7, missing on beat 15.
      for (int k = 0; k < BEATS; k++) begin
         send_beat(9, k, k == 7);
         if (k == 6) chk("framing_clean_before", 512'(err_framing), 512'(0));
         if (k == 7) chk("framing_flag_beat7", 512'(err_framing), 512'(1));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("framing_start", 512'(start), 512'(1));
      chk("framing_w_flat", o_weights_flat, exp_w(9));
      chk("framing_a_flat", o_acts_flat, exp_a(9));
      @(posedge clk); #1;
      chk("framing_vec_cnt", 512'(vec_cnt), 512'(5));

      // Reset mid-vector, asserted between edges.
      for (int k = 0; k < 10; k++) send_beat(11, k, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Underflow from reset state.
      pulse_done();
      chk("underflow_flag", 512'(err_underflow), 512'(1));
      chk("underflow_outstanding", 512'(outstanding), 512'(0));

      // Fresh vector after reset issues once with only new data.
      send_vec(13);
      chk("fresh_start", 512'(start), 512'(1));
      chk("fresh_w_flat", o_weights_flat, exp_w(13));
      chk("fresh_a_flat", o_acts_flat, exp_a(13));
      chk("fresh_outstanding", 512'(outstanding), 512'(1));
      @(posedge clk); #1;
      chk("fresh_start_drop", 512'(start), 512'(0));
      chk("fresh_vec_cnt", 512'(vec_cnt), 512'(1));
      chk("fresh_framing_clear", 512'(err_framing), 512'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dot_operand_loader.md
# dot_operand_loader

Upstream feeder for `naive_dot`. Accepts weight/activation element pairs as a narrow valid/ready beat stream (LANES pairs per beat) and assembles them into one N-element flat vector. When a vector is complete, it issues a single-cycle `start` with the flat weight and activation buses. Outstanding dot products are tracked against returned `done` pulses, so issue is throttled to a fixed credit limit.

## Interface
- `N`, 128: elements per dot-product vector.
- `WEIGHT_WIDTH`, 4: bits per weight element.
- `ACT_WIDTH`, 4: bits per activation element.
- `LANES`, 8: element pairs per input beat. N must be a multiple of LANES. BEATS = N/LANES.
- `MAX_OUT`, 4: maximum issued-but-not-done vectors (≥1).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_weights`  in  LANES*WEIGHT_WIDTH  lane j at bits [j*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `in_acts`  in  LANES*ACT_WIDTH  lane j at bits [j*ACT_WIDTH +: ACT_WIDTH].
- `in_last`  in  1  sender marks final beat of a vector (checked only).
- `done_in`  in  1  downstream `done` pulse, one per completed vector.
- `start`  out  1  one-cycle issue strobe to downstream.
- `o_weights_flat`  out  N*WEIGHT_WIDTH  assembled weights, element i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `o_acts_flat`  out  N*ACT_WIDTH  assembled activations, same indexing.
- `outstanding`  out  $clog2(MAX_OUT+1)  current credit usage.
- `vec_cnt`  out  16  vectors issued, wraps at 2^16.
- `err_framing`  out  1  sticky: `in_last` misaligned with beat count.
- `err_underflow`  out  1  sticky: `done_in` while `outstanding`==0.

## Operation
- Fill buffer holds N pairs, with beat counter `beat_cnt` in 0..BEATS-1.
- Accepted beat k, lane j writes element k*LANES+j, then `beat_cnt` increments. On beat BEATS-1, `beat_cnt` wraps to 0.
- On acceptance of beat BEATS-1 (the final beat):
  - the complete buffer, including that beat's lanes, is copied into the output registers `o_weights_flat`/`o_acts_flat`;
  - `start` is registered high for the next cycle;
  - `outstanding` is incremented.
- Output registers load only on final-beat acceptance. Between issues they hold their value.
- Because the output registers are separate from the fill buffer, filling of the next vector continues with no bubble.
- Credit rule: `in_ready` = !(`beat_cnt`==BEATS-1 && `outstanding`==MAX_OUT). Only the final beat stalls; earlier beats are always accepted.
- `outstanding` update, per cycle:
  - +1 on final-beat acceptance;
  - -1 on `done_in` when `outstanding`>0;
  - both in the same cycle: unchanged;
  - `done_in` at 0: stays 0 and sets `err_underflow`.
- Framing check: `err_framing` sets when an accepted beat has `in_last` != (`beat_cnt`==BEATS-1). Data and beat counting proceed unchanged; `in_last` never alters assembly.
- `vec_cnt` increments in the cycle `start` is high.
- Error flags clear only on reset.

## Timing
- Reset values: `in_ready`=1, `start`=0, flat outputs all 0, `outstanding`=0, `vec_cnt`=0, both errors 0, `beat_cnt`=0, fill buffer 0.
- Latency: final beat accepted at edge t → `start`=1 during cycle t+1 with valid flat buses. `start` is never high two consecutive cycles unless BEATS==1.
- With BEATS==1, back-to-back `start` is allowed every cycle while credits remain.
- Peak throughput: one vector per BEATS cycles.
- A `done_in` arriving in the same cycle the stall condition holds does not raise `in_ready` that cycle. Ready rises the following cycle. `in_ready` has no combinational path from `done_in`.
- Reset mid-vector:
  - the partial vector is discarded (`beat_cnt`→0);
  - any pending `start` is cancelled;
  - `outstanding` clears, so done pulses still in flight afterwards flag `err_underflow`.
- `in_valid` low mid-vector: pauses assembly indefinitely, no timeout.

## Test plan
- Single vector, defaults: 16 beats, element i = weight i%16, act (15-i)%16, `in_last` on beat 15 → `start` one cycle after beat 15, flat buses match element map exactly, `outstanding`=1, `vec_cnt`=1.
- Credit stall, MAX_OUT=2, `done_in` held 0, 3 vectors streamed → first two issue; on the third vector's beat 15 `in_ready`=0. Pulse `done_in` once → `in_ready`=1 next cycle, third `start` follows, `outstanding` back to 2.
- Simultaneous `done_in` with final-beat acceptance at `outstanding`=1 → `outstanding` stays 1, `start` still issues, `vec_cnt`+1.
- Framing: `in_last` asserted on beat 7 and omitted on beat 15 → `err_framing`=1 after beat 7. Vector still issues after beat 15 with correct data.
- Underflow: `done_in` pulse at reset state → `err_underflow`=1, `outstanding` stays 0.
- Reset mid-vector: assert `rst` asynchronously after beat 9 → all outputs at reset values immediately. A fresh 16-beat vector afterwards issues once with only new data.
